// File: rtl/taiga_types.sv
// Shared fetch-path types: fetch-group record, prefetch FSM states and PC helpers.
package taiga_types;

   localparam int MAX_FETCH_WIDTH = 4;

   typedef enum logic [0:0] {
      RUN         = 1'b0,
      STALL_FAULT = 1'b1
   } fetch_state_t;

   // Sized for the widest legal group so one type serves every FETCH_WIDTH.
   typedef struct packed {
      logic [31:0]                       addr;
      logic [MAX_FETCH_WIDTH-1:0][31:0]  data;
      logic                              fault;
      logic [1:0]                        first_slot;
   } fetch_group_t;

   function automatic logic [1:0] word_index(input logic [31:0] pc, input int fetch_width);
      logic [31:0] idx;
      idx = (pc >> 2) & 32'(fetch_width - 1);
      return idx[1:0];
   endfunction

   function automatic logic [31:0] group_align(input logic [31:0] pc, input int fetch_width);
      return pc & ~(32'(4 * fetch_width) - 32'd1);
   endfunction

endpackage

// File: rtl/taiga_fifo.sv
// Generic synchronous FIFO, any depth >= 1; a push into a full FIFO is accepted when a pop
// happens in the same cycle. clear empties it; rd data is the head, valid while !empty.
module taiga_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4,
   localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic                  empty,
   output logic                  full,
   output logic [CW-1:0]         count
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;
   logic                  push_ok;
   logic                  pop_ok;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty    = (count == '0);
   assign full     = (count == CW'(FIFO_DEPTH));
   assign pop_ok   = pop & ~empty;
   assign push_ok  = push & (~full | pop_ok);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
         if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !clear) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: credit-limited group fetch, epoch-tagged in-order responses,
// per-instruction dequeue with 1-cycle response-to-decode latency; redirect flushes in one cycle.
module fetch_prefetch_queue
   import taiga_types::*;
#(
   parameter int          FETCH_WIDTH     = 2,
   parameter int          QUEUE_DEPTH     = 4,
   parameter int          MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_PC        = 32'h8000_0000
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     req_valid,
   input  logic                     req_ready,
   output logic [31:0]              req_addr,
   input  logic                     rsp_valid,
   input  logic [32*FETCH_WIDTH-1:0] rsp_data,
   input  logic                     rsp_fault,
   input  logic                     redirect_valid,
   input  logic [31:0]              redirect_pc,
   input  logic                     hold,
   output logic                     dec_valid,
   input  logic                     dec_ready,
   output logic [31:0]              dec_instr,
   output logic [31:0]              dec_pc,
   output logic                     dec_fault
);

   localparam logic [31:0] GROUP_BYTES = 32'(4 * FETCH_WIDTH);
   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int QCNT_W = $clog2(QUEUE_DEPTH + 1);
   localparam int GW = $bits(fetch_group_t);

   fetch_state_t state, state_next;

   logic [31:0]      fetch_pc;
   logic [31:0]      rsp_pc;
   logic [1:0]       first_slot;
   logic [1:0]       slot_ptr;
   logic             epoch;
   logic [OUT_W-1:0] outstanding;

   logic              issue;
   logic              credit_ok;
   logic              enq;
   logic              deq;
   logic              q_pop;
   logic              last_slot;
   logic [1:0]        cur_slot;
   fetch_group_t      enq_group;
   fetch_group_t      head;
   logic [GW-1:0]     q_head_raw;
   logic              q_empty;
   logic              q_full;
   logic [QCNT_W-1:0] q_count;
   logic [0:0]        tag_epoch;
   logic              tag_empty;
   logic              tag_full;
   logic [OUT_W-1:0]  tag_count;

   assign credit_ok = (32'(outstanding) + 32'(q_count) < 32'(QUEUE_DEPTH)) &&
                      (32'(outstanding) < 32'(MAX_OUTSTANDING));
   assign req_valid = ~rst & (state == RUN) & ~hold & ~redirect_valid & credit_ok;
   assign req_addr  = fetch_pc;
   assign issue     = req_valid & req_ready;

   // Stale = older epoch, same-cycle redirect, or anything trailing a faulted group.
   assign enq = rsp_valid & ~redirect_valid & (tag_epoch[0] == epoch) & (state == RUN);

   always_comb begin
      enq_group            = '0;
      enq_group.addr       = rsp_pc;
      enq_group.fault      = rsp_fault;
      enq_group.first_slot = first_slot;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         enq_group.data[i] = rsp_data[32*i +: 32];
      end
   end

   taiga_fifo #(
      .DATA_WIDTH (GW),
      .FIFO_DEPTH (QUEUE_DEPTH)
   ) u_group_q (
      .clk       (clk),
      .rst       (rst),
      .clear     (redirect_valid),
      .push      (enq),
      .push_data (enq_group),
      .pop       (q_pop),
      .pop_data  (q_head_raw),
      .empty     (q_empty),
      .full      (q_full),
      .count     (q_count)
   );

   // Never cleared: stale tags must still be popped by their responses.
   taiga_fifo #(
      .DATA_WIDTH (1),
      .FIFO_DEPTH (MAX_OUTSTANDING)
   ) u_epoch_q (
      .clk       (clk),
      .rst       (rst),
      .clear     (1'b0),
      .push      (issue),
      .push_data (epoch),
      .pop       (rsp_valid),
      .pop_data  (tag_epoch),
      .empty     (tag_empty),
      .full      (tag_full),
      .count     (tag_count)
   );

   assign head      = q_head_raw;
   assign cur_slot  = (slot_ptr > head.first_slot) ? slot_ptr : head.first_slot;
   assign last_slot = head.fault | (cur_slot == 2'(FETCH_WIDTH - 1));
   assign dec_valid = ~rst & ~redirect_valid & ~q_empty;
   assign deq       = dec_valid & dec_ready;
   assign q_pop     = deq & last_slot;
   assign dec_instr = dec_valid ? head.data[cur_slot] : 32'd0;
   assign dec_pc    = dec_valid ? head.addr + 32'({cur_slot, 2'b00}) : 32'd0;
   assign dec_fault = dec_valid & head.fault;

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= group_align(RESET_PC, FETCH_WIDTH);
         rsp_pc      <= group_align(RESET_PC, FETCH_WIDTH);
         first_slot  <= word_index(RESET_PC, FETCH_WIDTH);
         slot_ptr    <= '0;
         epoch       <= 1'b0;
         outstanding <= '0;
      end else begin
         case ({issue, rsp_valid})
            2'b10:   outstanding <= outstanding + OUT_W'(1);
            2'b01:   outstanding <= outstanding - OUT_W'(1);
            default: outstanding <= outstanding;
         endcase
         if (redirect_valid) begin
            epoch      <= ~epoch;
            fetch_pc   <= group_align(redirect_pc, FETCH_WIDTH);
            rsp_pc     <= group_align(redirect_pc, FETCH_WIDTH);
            first_slot <= word_index(redirect_pc, FETCH_WIDTH);
            slot_ptr   <= '0;
         end else begin
            if (issue) fetch_pc <= fetch_pc + GROUP_BYTES;
            if (enq) begin
               rsp_pc     <= rsp_pc + GROUP_BYTES;
               first_slot <= '0;
            end
            if (deq) slot_ptr <= last_slot ? 2'd0 : cur_slot + 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (redirect_valid) begin
         state_next = RUN;
      end else begin
         case (state)
            RUN:         if (enq && rsp_fault) state_next = STALL_FAULT;
            STALL_FAULT: state_next = STALL_FAULT;
            default:     state_next = RUN;
         endcase
      end
   end

   a_rsp_has_request: assert property (@(posedge clk) disable iff (rst)
      rsp_valid |-> (outstanding != '0) && !tag_empty);
   a_tag_no_overflow: assert property (@(posedge clk) disable iff (rst)
      issue |-> !tag_full);
   a_tag_tracks_outstanding: assert property (@(posedge clk) disable iff (rst)
      tag_count == outstanding);
   a_queue_has_room: assert property (@(posedge clk) disable iff (rst)
      enq |-> (!q_full || q_pop));

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench: per-cycle vector table for reset/streaming/full-queue, then hand sequences
// for backpressure, misaligned redirect, fault stall, address wrap and simultaneous events.
module tb_fetch_prefetch_queue;

   localparam int FW = 2;
   localparam int QD = 4;
   localparam int MO = 2;
   localparam logic [31:0] GMASK = ~32'(4 * FW - 1);

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            req_valid;
   logic            req_ready = 1'b1;
   logic [31:0]     req_addr;
   logic            rsp_valid = 1'b0;
   logic [32*FW-1:0] rsp_data = '0;
   logic            rsp_fault = 1'b0;
   logic            redirect_valid = 1'b0;
   logic [31:0]     redirect_pc = '0;
   logic            hold = 1'b0;
   logic            dec_valid;
   logic            dec_ready = 1'b0;
   logic [31:0]     dec_instr;
   logic [31:0]     dec_pc;
   logic            dec_fault;

   always #5 clk = ~clk;

   fetch_prefetch_queue #(
      .FETCH_WIDTH     (FW),
      .QUEUE_DEPTH     (QD),
      .MAX_OUTSTANDING (MO),
      .RESET_PC        (32'h8000_0000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_addr       (req_addr),
      .rsp_valid      (rsp_valid),
      .rsp_data       (rsp_data),
      .rsp_fault      (rsp_fault),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .hold           (hold),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_instr      (dec_instr),
      .dec_pc         (dec_pc),
      .dec_fault      (dec_fault)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Memory model: in-order, one response per cycle, one cycle after acceptance unless paused.
   logic [31:0] pending[$];
   bit          mem_pause = 1'b0;
   logic [31:0] fault_addr = 32'h1;

   logic        s_req_valid, s_dec_valid, s_dec_fault;
   logic [31:0] s_req_addr, s_dec_pc, s_dec_instr;

   logic [31:0] exp_pc = 32'h8000_0000;
   logic [31:0] last_pc = '0;
   logic [31:0] first_cons = '0;
   logic [31:0] watch_addr [2];
   int          watch_n = 0;
   bit          cons_seen = 1'b0;
   int          n_cons = 0;
   int          fault_cnt = 0;
   int          issued_cnt = 0;

   task automatic cycle();
      logic [31:0] a;
      logic        exp_f;
      @(negedge clk);
      s_req_valid = req_valid;
      s_req_addr  = req_addr;
      s_dec_valid = dec_valid;
      s_dec_pc    = dec_pc;
      s_dec_instr = dec_instr;
      s_dec_fault = dec_fault;
      if (req_valid && req_ready) begin
         pending.push_back(req_addr);
         issued_cnt++;
         if (watch_n < 2) begin
            watch_addr[watch_n] = req_addr;
            watch_n++;
         end
      end
      if (dec_valid && dec_ready) begin
         exp_f = ((exp_pc & GMASK) == fault_addr);
         chk("stream_pc", dec_pc, exp_pc);
         chk("stream_fault", 32'(dec_fault), 32'(exp_f));
         if (!exp_f) chk("stream_instr", dec_instr, ~exp_pc);
         if (dec_fault) fault_cnt++;
         if (!cons_seen) begin
            first_cons = dec_pc;
            cons_seen  = 1'b1;
         end
         last_pc = dec_pc;
         n_cons++;
         exp_pc = exp_pc + 32'd4;
      end
      @(posedge clk);
      #1;
      rsp_valid = 1'b0;
      rsp_fault = 1'b0;
      rsp_data  = '0;
      if (rst) begin
         pending.delete();
      end else if (!mem_pause && pending.size() > 0) begin
         a = pending.pop_front();
         rsp_valid = 1'b1;
         rsp_fault = (a == fault_addr);
         for (int i = 0; i < FW; i++) rsp_data[32*i +: 32] = ~(a + 32'(4 * i));
      end
   endtask

   task automatic do_redirect(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      exp_pc         = {pc[31:2], 2'b00};
      watch_n        = 0;
      watch_addr[0]  = 'x;
      watch_addr[1]  = 'x;
      cons_seen      = 1'b0;
      first_cons     = 'x;
      cycle();
      redirect_valid = 1'b0;
   endtask

   typedef struct {
      logic        dr;
      logic        rv;
      logic [31:0] ra;
      logic        dv;
      logic [31:0] dp;
   } vec_t;

   vec_t tbl [18];

   initial begin
      bit found;
      int n0;

      // {dec_ready, exp req_valid, exp req_addr, exp dec_valid, exp dec_pc}, one row per cycle
      tbl[0]  = '{1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'h0};
      tbl[1]  = '{1'b1, 1'b1, 32'h8000_0008, 1'b0, 32'h0};
      tbl[2]  = '{1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0000};
      tbl[3]  = '{1'b1, 1'b1, 32'h8000_0018, 1'b1, 32'h8000_0004};
      tbl[4]  = '{1'b1, 1'b1, 32'h8000_0020, 1'b1, 32'h8000_0008};
      tbl[5]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_000C};
      tbl[6]  = '{1'b1, 1'b1, 32'h8000_0028, 1'b1, 32'h8000_0010};
      tbl[7]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_0014};
      tbl[8]  = '{1'b1, 1'b1, 32'h8000_0030, 1'b1, 32'h8000_0018};
      tbl[9]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_001C};
      tbl[10] = '{1'b1, 1'b1, 32'h8000_0038, 1'b1, 32'h8000_0020};
      tbl[11] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_0024};
      tbl[12] = '{1'b0, 1'b1, 32'h8000_0040, 1'b1, 32'h8000_0028};
      tbl[13] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0028};
      tbl[14] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0028};
      tbl[15] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_0028};
      tbl[16] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_002C};
      tbl[17] = '{1'b1, 1'b1, 32'h8000_0048, 1'b1, 32'h8000_0030};

      rst = 1'b1;
      cycle();
      cycle();
      chk("rst_req_valid", 32'(s_req_valid), 32'd0);
      chk("rst_dec_valid", 32'(s_dec_valid), 32'd0);
      chk("rst_dec_instr", s_dec_instr, 32'd0);
      chk("rst_dec_pc", s_dec_pc, 32'd0);
      chk("rst_dec_fault", 32'(s_dec_fault), 32'd0);
      rst = 1'b0;

      for (int r = 0; r < 18; r++) begin
         dec_ready = tbl[r].dr;
         cycle();
         chk($sformatf("tbl%0d_req_valid", r), 32'(s_req_valid), 32'(tbl[r].rv));
         if (tbl[r].rv) chk($sformatf("tbl%0d_req_addr", r), s_req_addr, tbl[r].ra);
         chk($sformatf("tbl%0d_dec_valid", r), 32'(s_dec_valid), 32'(tbl[r].dv));
         if (tbl[r].dv) begin
            chk($sformatf("tbl%0d_dec_pc", r), s_dec_pc, tbl[r].dp);
            chk($sformatf("tbl%0d_dec_instr", r), s_dec_instr, ~tbl[r].dp);
         end
      end

      // Backpressure: queue fills, requests stop, stream resumes gap-free.
      dec_ready  = 1'b0;
      issued_cnt = 0;
      repeat (20) cycle();
      chk("bp_issued_le_depth", 32'(issued_cnt <= QD), 32'd1);
      chk("bp_req_idle", 32'(s_req_valid), 32'd0);
      chk("bp_dec_held", 32'(s_dec_valid), 32'd1);
      dec_ready = 1'b1;
      n0 = n_cons;
      repeat (30) cycle();
      chk("bp_resume_rate", 32'(n_cons - n0), 32'd30);

      // Misaligned redirect with two requests in flight.
      mem_pause = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle();
         if (pending.size() == MO && !rsp_valid) found = 1'b1;
      end
      chk("redir_inflight", 32'(found), 32'd1);
      do_redirect(32'h8000_0104);
      chk("redir_req_blocked", 32'(s_req_valid), 32'd0);
      chk("redir_dec_blocked", 32'(s_dec_valid), 32'd0);
      mem_pause = 1'b0;
      cycle();
      chk("redir_queue_cleared", 32'(s_dec_valid), 32'd0);
      repeat (20) cycle();
      chk("redir_first_req", watch_addr[0], 32'h8000_0100);
      chk("redir_first_pc", first_cons, 32'h8000_0104);

      // Faulting group stops the stream after one faulted instruction.
      fault_addr = 32'h8000_0010;
      do_redirect(32'h8000_0000);
      n0 = n_cons;
      fault_cnt = 0;
      repeat (40) cycle();
      chk("fault_count", 32'(fault_cnt), 32'd1);
      chk("fault_last_pc", last_pc, 32'h8000_0010);
      chk("fault_consumed", 32'(n_cons - n0), 32'd5);
      chk("fault_no_req", 32'(s_req_valid), 32'd0);
      chk("fault_dec_idle", 32'(s_dec_valid), 32'd0);
      chk("fault_mem_idle", 32'(pending.size()), 32'd0);
      fault_addr = 32'h1;
      do_redirect(32'h8000_0000);
      repeat (20) cycle();
      chk("fault_resume_req", watch_addr[0], 32'h8000_0000);
      chk("fault_resume_pc", first_cons, 32'h8000_0000);
      chk("fault_resume_count", 32'(fault_cnt), 32'd1);

      // Address wrap.
      do_redirect(32'hFFFF_FFF8);
      repeat (20) cycle();
      chk("wrap_req0", watch_addr[0], 32'hFFFF_FFF8);
      chk("wrap_req1", watch_addr[1], 32'h0000_0000);
      chk("wrap_first_pc", first_cons, 32'hFFFF_FFF8);

      // Redirect coinciding with a response and dec_ready.
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle();
         if (rsp_valid) found = 1'b1;
      end
      chk("simul_rsp_seen", 32'(found), 32'd1);
      do_redirect(32'h8000_0200);
      chk("simul_dec_blocked", 32'(s_dec_valid), 32'd0);
      repeat (20) cycle();
      chk("simul_first_pc", first_cons, 32'h8000_0200);

      // hold stops requests only; the queue still drains.
      hold = 1'b1;
      repeat (12) cycle();
      chk("hold_req_idle", 32'(s_req_valid), 32'd0);
      chk("hold_drained", 32'(s_dec_valid), 32'd0);
      chk("hold_mem_idle", 32'(pending.size()), 32'd0);

      // With nothing outstanding and decode stalled, exactly QUEUE_DEPTH groups are fetched.
      hold = 1'b0;
      dec_ready = 1'b0;
      issued_cnt = 0;
      repeat (20) cycle();
      chk("credit_refill", 32'(issued_cnt), 32'(QD));
      chk("credit_req_idle", 32'(s_req_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
